inst_fetch_unit: RTL and testbench

// - PC register plus fetch FSM that feeds 32-bit instructions to the control decoder.
// - Takes the decoder's Jump/Branch outputs back from the consumer and computes the next PC.
// - Talks a req/valid handshake to instruction memory.
// - Presents inst/pc/pc+4 to the datapath.

---
 rtl/inst_fetch_unit.sv | 176 +++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Purpose: PC register and fetch FSM feeding one 32-bit instruction at a time to the decoder.
// Latency: imem_valid -> inst_valid 1 cycle; inst_ready -> next imem_req 1 cycle (1 inst / 2 cycles peak).
// Backpressure: holds inst_o/pc_o with inst_valid high until inst_ready; imem_req holds until imem_valid.
// Optional feature: define BRANCH_DELAY_SLOT_EN to execute one delay-slot instruction after a taken redirect.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_3000,
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_o,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    input  logic [1:0]  Jump,
    input  logic        Branch,
    input  logic        zero,
    input  logic [31:0] rs_data,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } state_t;

    // wait_cnt value at which one more missed cycle means the timeout has been reached
    localparam logic [15:0] TIMEOUT_LAST = 16'(WAIT_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        err_q, err_d;
    logic [15:0] wait_q, wait_d;

    logic [31:0] pc_plus4;
    logic [31:0] br_off;
    logic [31:0] target;
    logic        unaligned;

`ifdef BRANCH_DELAY_SLOT_EN
    logic        pend_q, pend_d;
    logic [31:0] ptgt_q, ptgt_d;
    logic        redirect;

    // any jump or taken branch moves the target into the pending slot
    assign redirect = (Jump == 2'd1) || (Jump == 2'd2) || (Branch && zero);
`endif

    // redirect target selection; Jump outranks Branch, Jump==3 behaves as no jump
    always_comb begin
        pc_plus4  = pc_q + 32'd4;
        br_off    = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
        target    = pc_plus4;
        unaligned = 1'b0;
        case (Jump)
            2'd1: target = {pc_plus4[31:28], inst_q[25:0], 2'b00};
            2'd2: begin
                target    = rs_data;
                unaligned = (rs_data[1:0] != 2'b00);
            end
            default: begin
                if (Branch && zero) begin
                    target = pc_plus4 + br_off;
                end
            end
        endcase
    end

    // next-state and handshake outputs of the fetch FSM
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        err_d      = err_q;
        wait_d     = wait_q;
        imem_req   = 1'b0;
        inst_valid = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
        pend_d     = pend_q;
        ptgt_d     = ptgt_q;
`endif
        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    inst_d  = imem_rdata;
                    wait_d  = 16'd0;
                    state_d = ISSUE;
                end else begin
                    wait_d = wait_q + 16'd1;
                    if (wait_q == TIMEOUT_LAST) begin
                        err_d   = 1'b1;
                        state_d = HALT;
                    end
                end
            end
            ISSUE: begin
                inst_valid = 1'b1;
                if (inst_ready) begin
`ifdef BRANCH_DELAY_SLOT_EN
                    // the delay-slot instruction's own control flow is ignored
                    if (pend_q) begin
                        pc_d    = ptgt_q;
                        pend_d  = 1'b0;
                        state_d = FETCH;
                    end else if (unaligned) begin
                        err_d   = 1'b1;
                        state_d = HALT;
                    end else if (redirect) begin
                        pc_d    = pc_plus4;
                        ptgt_d  = target;
                        pend_d  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        pc_d    = pc_plus4;
                        state_d = FETCH;
                    end
`else
                    if (unaligned) begin
                        err_d   = 1'b1;
                        state_d = HALT;
                    end else begin
                        pc_d    = target;
                        state_d = FETCH;
                    end
`endif
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // state register; reset discards any in-flight instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            inst_q  <= 32'd0;
            err_q   <= 1'b0;
            wait_q  <= 16'd0;
`ifdef BRANCH_DELAY_SLOT_EN
            pend_q  <= 1'b0;
            ptgt_q  <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
`ifdef BRANCH_DELAY_SLOT_EN
            pend_q  <= pend_d;
            ptgt_q  <= ptgt_d;
`endif
        end
    end

    assign imem_addr  = pc_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4;
    assign inst_o     = inst_q;
    assign fetch_err  = err_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

    localparam int          TO  = 20;
    localparam logic [31:0] RPC = 32'h0000_3000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] inst_o;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic [1:0]  Jump;
    logic        Branch;
    logic        zero;
    logic [31:0] rs_data;
    logic        fetch_err;

    int total = 0;
    int bad   = 0;

    // model: where the unit is in its fetch/consume cycle
    localparam int M_WAITMEM = 0;
    localparam int M_HOLDING = 1;
    localparam int M_STOPPED = 2;

    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic        m_err;
    int          m_missed;
    logic        m_pend;
    logic [31:0] m_ptgt;

    inst_fetch_unit #(.RESET_PC(RPC), .WAIT_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .inst_o(inst_o), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
        .Jump(Jump), .Branch(Branch), .zero(zero), .rs_data(rs_data),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // where control goes after consuming inst at pc; tk says whether it leaves the sequential path
    function automatic logic [31:0] dest(input logic [31:0] pc, input logic [31:0] inst,
                                         input logic [1:0] j, input logic b, input logic z,
                                         input logic [31:0] rs, output logic tk);
        logic [31:0]        nxt;
        logic signed [31:0] off;
        nxt = pc + 32'd4;
        off = $signed(inst[15:0]);
        tk  = 1'b1;
        if (j == 2'd1)      return (nxt & 32'hF000_0000) | ((inst & 32'h03FF_FFFF) * 4);
        else if (j == 2'd2) return rs;
        else if (b && z)    return nxt + 32'(off * 4);
        tk = 1'b0;
        return nxt;
    endfunction

    task automatic model_step(input logic r, input logic iv, input logic [31:0] rd,
                              input logic ir, input logic [1:0] j, input logic b,
                              input logic z, input logic [31:0] rs);
        logic        tk;
        logic [31:0] d;
        if (r) begin
            m_mode = M_WAITMEM; m_pc = RPC; m_inst = 0; m_err = 0; m_missed = 0; m_pend = 0;
        end else if (m_mode == M_WAITMEM) begin
            if (iv) begin
                m_inst = rd; m_mode = M_HOLDING; m_missed = 0;
            end else begin
                m_missed++;
                if (m_missed == TO) begin m_err = 1; m_mode = M_STOPPED; end
            end
        end else if (m_mode == M_HOLDING && ir) begin
            d = dest(m_pc, m_inst, j, b, z, rs, tk);
`ifdef BRANCH_DELAY_SLOT_EN
            if (m_pend) begin
                m_pc = m_ptgt; m_pend = 0; m_mode = M_WAITMEM;
            end else if (j == 2'd2 && rs[1:0] != 0) begin
                m_err = 1; m_mode = M_STOPPED;
            end else begin
                if (tk) begin m_ptgt = d; m_pend = 1; end
                m_pc = m_pc + 4; m_mode = M_WAITMEM;
            end
`else
            if (j == 2'd2 && rs[1:0] != 0) begin
                m_err = 1; m_mode = M_STOPPED;
            end else begin
                m_pc = d; m_mode = M_WAITMEM;
            end
`endif
        end
    endtask

    task automatic compare_all();
        chk("imem_req", 32'(imem_req), 32'(m_mode == M_WAITMEM));
        chk("imem_addr", imem_addr, m_pc);
        chk("pc_o", pc_o, m_pc);
        chk("pc_plus4_o", pc_plus4_o, m_pc + 32'd4);
        chk("inst_valid", 32'(inst_valid), 32'(m_mode == M_HOLDING));
        chk("inst_o", inst_o, m_inst);
        chk("fetch_err", 32'(fetch_err), 32'(m_err));
    endtask

    // one clock: drive inputs, advance the model, then compare after the edge
    task automatic cyc(input logic r, input logic iv, input logic [31:0] rd, input logic ir,
                       input logic [1:0] j, input logic b, input logic z, input logic [31:0] rs);
        rst = r; imem_valid = iv; imem_rdata = rd; inst_ready = ir;
        Jump = j; Branch = b; zero = z; rs_data = rs;
        model_step(r, iv, rd, ir, j, b, z, rs);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic issue_one(input logic [31:0] rd, input logic [1:0] j, input logic b,
                             input logic z, input logic [31:0] rs);
        cyc(0, 1, rd, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, j, b, z, rs);
    endtask

    // after a redirect from 0x3000, the delay-slot build first executes 0x3004
    task automatic expect_target(input string name, input logic [31:0] tgt);
`ifdef BRANCH_DELAY_SLOT_EN
        chk({name, "_slot"}, imem_addr, 32'h0000_3004);
        issue_one(32'd0, 2'd3, 1, 1, 32'h0000_0001);
`endif
        chk(name, imem_addr, tgt);
    endtask

    initial begin
        logic r, iv, ir, b, z;
        logic [1:0]  j;
        logic [31:0] rd, rs;
        clk = 0; rst = 0; imem_valid = 0; imem_rdata = 0; inst_ready = 0;
        Jump = 0; Branch = 0; zero = 0; rs_data = 0;
        m_mode = M_WAITMEM; m_pc = RPC; m_inst = 0; m_err = 0; m_missed = 0;
        m_pend = 0; m_ptgt = 0;

        // reset state
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_req", 32'(imem_req), 32'd1);
        chk("rst_addr", imem_addr, 32'h0000_3000);
        chk("rst_ivld", 32'(inst_valid), 32'd0);
        chk("rst_err", 32'(fetch_err), 32'd0);

        // sequential nops
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        chk("seq_ivld", 32'(inst_valid), 32'd1);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        chk("seq_addr1", imem_addr, 32'h0000_3004);
        chk("seq_ivld_drop", 32'(inst_valid), 32'd0);
        issue_one(32'd0, 0, 0, 0, 0);
        chk("seq_addr2", imem_addr, 32'h0000_3008);

        // beq taken / not taken
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        issue_one(32'h1000_0003, 0, 1, 1, 0);
        expect_target("beq_taken", 32'h0000_3010);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        issue_one(32'h1000_0003, 0, 1, 0, 0);
        chk("beq_not", imem_addr, 32'h0000_3004);

        // j, jr, jr to the top word (pc+4 wraps)
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        issue_one(32'h0800_0C10, 1, 0, 0, 0);
        expect_target("j", 32'h0000_3040);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        issue_one(32'd0, 2, 0, 0, 32'h0000_3100);
        expect_target("jr", 32'h0000_3100);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        issue_one(32'd0, 2, 0, 0, 32'hFFFF_FFFC);
        expect_target("jr_top", 32'hFFFF_FFFC);
        chk("wrap_p4", pc_plus4_o, 32'd0);
        issue_one(32'd0, 0, 0, 0, 0);
        chk("wrap_addr", imem_addr, 32'd0);

        // unaligned jr halts
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        issue_one(32'd0, 2, 0, 0, 32'h0000_3102);
        chk("jr_bad_err", 32'(fetch_err), 32'd1);
        chk("jr_bad_req", 32'(imem_req), 32'd0);
        cyc(0, 1, 32'h1234_5678, 1, 0, 0, 0, 0);
        chk("halt_ivld", 32'(inst_valid), 32'd0);

        // memory timeout
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < TO - 1; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("to_early", 32'(fetch_err), 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("to_err", 32'(fetch_err), 32'd1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("to_clear", 32'(fetch_err), 32'd0);

        // reset while an instruction waits for consumption
        issue_one(32'h1000_0003, 0, 1, 1, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("mid_rst_addr", imem_addr, 32'h0000_3000);
        chk("mid_rst_ivld", 32'(inst_valid), 32'd0);
        issue_one(32'd0, 0, 0, 0, 0);
        chk("mid_rst_next", imem_addr, 32'h0000_3004);

        // randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            r  = (m_mode == M_STOPPED) ? ($urandom_range(3) == 0) : ($urandom_range(63) == 0);
            iv = ($urandom_range(2) == 0);
            rd = $urandom;
            ir = $urandom_range(1);
            j  = 2'($urandom_range(3));
            b  = $urandom_range(1);
            z  = $urandom_range(1);
            rs = $urandom;
            if ($urandom_range(7) != 0) rs[1:0] = 2'b00;
            cyc(r, iv, rd, ir, j, b, z, rs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
